tjmono_data_tx: RTL
===================

// Module: tjmono_data_tx
// PURPOSE
//  Chip-side emulator of the TJ-Monopix column readout: the transmitting end of the TOKEN/FREEZE/READ/DATA serial link.
//  Queues binary hits, raises TOKEN, snapshots the pending set on FREEZE, and shifts one 27-bit word per READ pulse.
//  Used in simulation and loopback firmware to drive tjmono_data_rx_core without a sensor attached.
// PARAMETERS
//  ASIZE        4  log2 of hit FIFO depth (depth = 2**ASIZE)
//  READ_LATENCY 4  RX_CLK cycles from READ rising edge detect to first DATA bit (1..15)
//  GRAY_EN      1  1: LE/TE sent Gray-coded; 0: sent binary
// PORTS
//  RX_CLK         in   1        single clock, used for all logic and serial output
//  RST            in   1        asynchronous, active-high reset
//  HIT_VALID      in   1        hit present on HIT_* this cycle
//  HIT_READY      out  1        FIFO can accept; push = HIT_VALID & HIT_READY
//  HIT_COL        in   6        column
//  HIT_ROW        in   9        row
//  HIT_LE         in   6        leading-edge timestamp, binary
//  HIT_TE         in   6        trailing-edge timestamp, binary
//  RX_FREEZE      in   1        freeze request from receiver, synchronous to RX_CLK
//  RX_READ        in   1        read strobe from receiver, synchronous to RX_CLK
//  RX_TOKEN       out  1        pending data in current (frozen or live) set
//  RX_DATA        out  1        serial data, MSB first
//  FIFO_LEVEL     out  ASIZE+1  words stored in FIFO
//  EMPTY_READ_CNT out  8        READs served with no frozen word; saturates at 255
//  READ_ERR       out  1        sticky: READ edge seen while not IDLE
// BEHAVIOUR
//  Reset: HIT_READY=0 during RST, 1 after; RX_TOKEN=0, RX_DATA=0, FIFO_LEVEL=0, EMPTY_READ_CNT=0, READ_ERR=0, FSM=IDLE.
//  Word format: {col[5:0], te[5:0], le[5:0], row[8:0]} = 27b. Fields le/te pass through gray_enc6 (g=b^(b>>1)) iff GRAY_EN.
//  Encoding happens on push; FIFO stores 27b encoded words.
//  Edge detect: freeze_r, read_r registered. FREEZE_RISE=RX_FREEZE&~freeze_r; READ_RISE=RX_READ&~read_r.
//  Frozen set: on FREEZE_RISE, frz_cnt <= FIFO_LEVEL (minus 1 if a pop occurs in the same cycle).
//  Pushes during freeze are outside the frozen set. frz_cnt=0 while RX_FREEZE=0.
//  RX_TOKEN (registered) = RX_FREEZE ? (frz_cnt!=0) : (FIFO_LEVEL!=0). It falls the cycle after the pop that empties the set.
//  FSM IDLE->WAIT->SHIFT->IDLE:
//   IDLE: on READ_RISE: if frz_cnt!=0 (or RX_FREEZE=0 with FIFO non-empty), pop FIFO into shift reg, decrement frz_cnt.
//    Otherwise load all-zeros and EMPTY_READ_CNT++. Then lat_cnt<=0 and go to WAIT.
//   WAIT: lat_cnt++; at lat_cnt==READ_LATENCY-1 go to SHIFT with bit_cnt<=26.
//   SHIFT: RX_DATA<=sh[26]; sh<<=1; bit_cnt--; after bit 0 go to IDLE and set RX_DATA<=0.
//  Latency: first bit on RX_DATA exactly READ_LATENCY+1 cycles after the RX_READ rising edge; 27 contiguous bits follow.
//  READ_RISE outside IDLE: ignored, READ_ERR<=1; the current word completes. A READ held high produces only one word.
//  FIFO full: HIT_READY=0, no push. Push and pop in the same cycle are legal even when full.
//  FIFO empty: no pop. Pointers wrap mod 2**ASIZE.
//  FREEZE falling mid-SHIFT: the word completes; RX_TOKEN reverts to the live FIFO state.
//  RST mid-word: everything aborts immediately, FIFO flushes, RX_DATA=0.
// STRUCTURE
//  Shared package tjmono_pkg: WORD_W=27, COL_W=6, ROW_W=9, TS_W=6, field offset localparams, FSM state encoding.
//  One sub-module gray_enc6 (6b binary->Gray, combinational), instantiated twice.
//  FIFO is inline: reg array plus ASIZE+1 pointers.
// TESTING
//  1. Push col=5,row=300,le=10,te=20; FREEZE then READ -> DATA=27'b000101_011110_001111_100101100.
//     First bit at READ+READ_LATENCY+1; TOKEN drops one cycle after READ detect.
//  2. Push 3 hits, FREEZE, push 2 more, issue 3 READs -> 3 words in push order.
//     TOKEN=0 after 3rd READ. Release FREEZE -> TOKEN=1 with FIFO_LEVEL=2.
//  3. READ with empty frozen set -> 27 zero bits, EMPTY_READ_CNT=1, TOKEN stays 0.
//     After 300 such READs -> EMPTY_READ_CNT=255.
//  4. Fill 16 hits with ASIZE=4 -> HIT_READY=0, FIFO_LEVEL=16; 17th hit held.
//     Accepted after first pop; push and pop in the same cycle keep LEVEL=16.
//  5. Second READ edge during SHIFT -> READ_ERR=1, first word intact, no extra pop.
//  6. Assert RST at bit 10 of a word -> RX_DATA=0, TOKEN=0, FIFO_LEVEL=0 next cycle, FSM=IDLE.
//     GRAY_EN=0 run: le=10 is sent as 001010.

Source files
------------

// File: rtl/tjmono_pkg.sv
// Shared definitions for the TJ-Monopix data link transmitter.
// Holds the 27-bit readout word geometry, the serializer FSM state
// encoding and a helper that packs hit fields into a link word.
package tjmono_pkg;

  localparam int WORD_W = 27;
  localparam int COL_W  = 6;
  localparam int ROW_W  = 9;
  localparam int TS_W   = 6;

  // Word layout, MSB first on the wire: {col, te, le, row}
  localparam int ROW_LSB = 0;
  localparam int LE_LSB  = ROW_LSB + ROW_W;
  localparam int TE_LSB  = LE_LSB + TS_W;
  localparam int COL_LSB = TE_LSB + TS_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] pack_word(
    input logic [COL_W-1:0] col,
    input logic [TS_W-1:0]  te,
    input logic [TS_W-1:0]  le,
    input logic [ROW_W-1:0] row
  );
    logic [WORD_W-1:0] w;
    w = '0;
    w[COL_LSB +: COL_W] = col;
    w[TE_LSB  +: TS_W]  = te;
    w[LE_LSB  +: TS_W]  = le;
    w[ROW_LSB +: ROW_W] = row;
    return w;
  endfunction

endpackage

// File: rtl/tjmono_data_tx_if.sv
// Hit input handshake plus the TOKEN/FREEZE/READ/DATA serial link.
// master: hit source / link receiver side (drives hits, FREEZE, READ)
// slave : transmitter side (drives HIT_READY, TOKEN, DATA)
interface tjmono_data_tx_if;

  logic                        HIT_VALID;
  logic                        HIT_READY;
  logic [tjmono_pkg::COL_W-1:0] HIT_COL;
  logic [tjmono_pkg::ROW_W-1:0] HIT_ROW;
  logic [tjmono_pkg::TS_W-1:0]  HIT_LE;
  logic [tjmono_pkg::TS_W-1:0]  HIT_TE;
  logic                        RX_FREEZE;
  logic                        RX_READ;
  logic                        RX_TOKEN;
  logic                        RX_DATA;

  modport master (
    output HIT_VALID, HIT_COL, HIT_ROW, HIT_LE, HIT_TE, RX_FREEZE, RX_READ,
    input  HIT_READY, RX_TOKEN, RX_DATA
  );

  modport slave (
    input  HIT_VALID, HIT_COL, HIT_ROW, HIT_LE, HIT_TE, RX_FREEZE, RX_READ,
    output HIT_READY, RX_TOKEN, RX_DATA
  );

endinterface

// File: rtl/gray_enc6.sv
// 6-bit binary to Gray converter, purely combinational.
// Ports: b_i binary in, g_o Gray out.
module gray_enc6 (
  input  logic [5:0] b_i,
  output logic [5:0] g_o
);

  assign g_o = b_i ^ (b_i >> 1);

endmodule

// File: rtl/tjmono_data_tx.sv
// Chip-side emulator of the TJ-Monopix column readout (transmit end).
// Queues hits in a small FIFO, raises TOKEN while data is pending,
// snapshots the pending count on FREEZE and serializes one 27-bit word
// per READ rising edge, MSB first, READ_LATENCY+1 cycles after the edge.
// Ports:
//   RX_CLK         clock for all logic and the serial output
//   RST            asynchronous active-high reset
//   bus            hit handshake and serial link (slave side)
//   FIFO_LEVEL     words currently stored
//   EMPTY_READ_CNT READs answered with an all-zero word (saturating)
//   READ_ERR       sticky: READ edge arrived while a word was in flight
module tjmono_data_tx
  import tjmono_pkg::*;
#(
  parameter int ASIZE        = 4,
  parameter int READ_LATENCY = 4,
  parameter bit GRAY_EN      = 1'b1
) (
  input  logic             RX_CLK,
  input  logic             RST,
  tjmono_data_tx_if.slave  bus,
  output logic [ASIZE:0]   FIFO_LEVEL,
  output logic [7:0]       EMPTY_READ_CNT,
  output logic             READ_ERR
);

  localparam int             DEPTH    = 1 << ASIZE;
  localparam logic [ASIZE:0] ONE_P    = 1;
  localparam logic [ASIZE:0] FULL_LVL = DEPTH[ASIZE:0];
  localparam logic [3:0]     LAT_LAST = 4'(READ_LATENCY - 1);

  // Field encoding happens before the FIFO so stored words are wire-ready
  logic [TS_W-1:0]   le_gray, te_gray, le_enc, te_enc;
  logic [WORD_W-1:0] push_word;

  gray_enc6 u_gray_le (.b_i(bus.HIT_LE), .g_o(le_gray));
  gray_enc6 u_gray_te (.b_i(bus.HIT_TE), .g_o(te_gray));

  assign le_enc    = GRAY_EN ? le_gray : bus.HIT_LE;
  assign te_enc    = GRAY_EN ? te_gray : bus.HIT_TE;
  assign push_word = pack_word(bus.HIT_COL, te_enc, le_enc, bus.HIT_ROW);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [ASIZE:0]    wr_ptr_q, rd_ptr_q, level, level_d;
  logic              full, push, pop, avail;
  logic              freeze_q, read_q, freeze_rise, read_rise;
  logic [ASIZE:0]    frz_cnt_q, frz_cnt_d, frz_eff;
  logic              token_q, token_d;
  state_t            state_q, state_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic              data_q, data_d;
  logic [7:0]        empty_cnt_q, empty_cnt_d;
  logic              read_err_q, read_err_d;

  assign level       = wr_ptr_q - rd_ptr_q;
  assign full        = (level == FULL_LVL);
  assign freeze_rise = bus.RX_FREEZE & ~freeze_q;
  assign read_rise   = bus.RX_READ & ~read_q;

  // On the freeze edge itself the snapshot is the live level, so a READ
  // arriving in that same cycle is served from the newly frozen set.
  assign frz_eff = freeze_rise ? level : frz_cnt_q;
  assign avail   = bus.RX_FREEZE ? (frz_eff != '0) : (level != '0);
  assign pop     = (state_q == ST_IDLE) & read_rise & avail;

  // A full FIFO still accepts a word in the cycle a pop frees a slot
  assign bus.HIT_READY = ~RST & (~full | pop);
  assign push          = bus.HIT_VALID & bus.HIT_READY;
  assign level_d       = level + {{ASIZE{1'b0}}, push} - {{ASIZE{1'b0}}, pop};

  always_comb begin
    frz_cnt_d = frz_eff;
    if (!bus.RX_FREEZE) begin
      frz_cnt_d = '0;
    end else if (pop) begin
      frz_cnt_d = frz_eff - ONE_P;
    end
  end

  // TOKEN looks at next-state counts so it drops right after the last pop
  assign token_d = bus.RX_FREEZE ? (frz_cnt_d != '0) : (level_d != '0);

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    lat_cnt_d   = lat_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    empty_cnt_d = empty_cnt_q;
    read_err_d  = read_err_q;

    if (read_rise && (state_q != ST_IDLE)) begin
      read_err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        data_d = 1'b0;
        if (read_rise) begin
          if (pop) begin
            sh_d = mem_q[rd_ptr_q[ASIZE-1:0]];
          end else begin
            sh_d = '0;
            if (empty_cnt_q != 8'hFF) begin
              empty_cnt_d = empty_cnt_q + 8'd1;
            end
          end
          lat_cnt_d = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        lat_cnt_d = lat_cnt_q + 4'd1;
        if (lat_cnt_q == LAT_LAST) begin
          bit_cnt_d = 5'd26;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d = sh_q[WORD_W-1];
        sh_d   = {sh_q[WORD_W-2:0], 1'b0};
        if (bit_cnt_q == 5'd0) begin
          state_d = ST_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q - 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO storage: contents need no reset, the pointers define validity
  always_ff @(posedge RX_CLK) begin
    if (push) begin
      mem_q[wr_ptr_q[ASIZE-1:0]] <= push_word;
    end
  end

  always_ff @(posedge RX_CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      freeze_q    <= 1'b0;
      read_q      <= 1'b0;
      frz_cnt_q   <= '0;
      token_q     <= 1'b0;
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      lat_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      data_q      <= 1'b0;
      empty_cnt_q <= '0;
      read_err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ONE_P;
      if (pop)  rd_ptr_q <= rd_ptr_q + ONE_P;
      freeze_q    <= bus.RX_FREEZE;
      read_q      <= bus.RX_READ;
      frz_cnt_q   <= frz_cnt_d;
      token_q     <= token_d;
      state_q     <= state_d;
      sh_q        <= sh_d;
      lat_cnt_q   <= lat_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      empty_cnt_q <= empty_cnt_d;
      read_err_q  <= read_err_d;
    end
  end

  assign bus.RX_TOKEN   = token_q;
  assign bus.RX_DATA    = data_q;
  assign FIFO_LEVEL     = level;
  assign EMPTY_READ_CNT = empty_cnt_q;
  assign READ_ERR       = read_err_q;

endmodule
